// File: rtl/ppu_fetch_scheduler.sv
// ppu_fetch_scheduler
// -------------------
// Dot/scanline sequencer for the PPU. Owns the raster counters and decodes
// them into per-dot fetch-mode strobes for the VRAM fetch controller, the
// loopy v-register update strobes, the vblank flag and the odd-frame dot skip.
//
// Ports:
//   clock, reset        dot-domain clock, synchronous active-high reset
//   clock_EN            dot enable; counters and flag advance only when high
//   renderingEnabled    PPUMASK background-show OR sprite-show
//   nmiEnable           PPUCTRL bit 7
//   vblankClear         one-cycle pulse on a CPU read of PPUSTATUS
//   dot, scanline       current raster position (registered)
//   frameOdd            odd-frame indicator (registered)
//   backgroundFetch_EN, spriteFetch_EN, dummyFetch_EN, idle
//                       one-hot fetch mode for the current dot (combinational)
//   coarseXIncrement, fineYIncrement, copyHorizontal, copyVertical
//                       loopy update strobes for the current dot (combinational)
//   vblankFlag          PPUSTATUS bit 7 (registered)
//   nmi_OUT             vblankFlag AND nmiEnable (combinational)
module ppu_fetch_scheduler #(
    parameter int DOTS_PER_LINE   = 341,
    parameter int LINES_PER_FRAME = 262,
    parameter int VBLANK_LINE     = 241
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clock_EN,
    input  logic       renderingEnabled,
    input  logic       nmiEnable,
    input  logic       vblankClear,
    output logic [8:0] dot,
    output logic [8:0] scanline,
    output logic       frameOdd,
    output logic       backgroundFetch_EN,
    output logic       spriteFetch_EN,
    output logic       dummyFetch_EN,
    output logic       idle,
    output logic       coarseXIncrement,
    output logic       fineYIncrement,
    output logic       copyHorizontal,
    output logic       copyVertical,
    output logic       vblankFlag,
    output logic       nmi_OUT
);

    localparam logic [8:0] LAST_DOT     = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] SKIP_DOT     = 9'(DOTS_PER_LINE - 2);
    localparam logic [8:0] PRE_LINE     = 9'(LINES_PER_FRAME - 1);
    localparam logic [8:0] VBL_LINE     = 9'(VBLANK_LINE);
    // The single post-render line sits directly before the vblank line, so
    // every line below it is a visible render line (0..239 on NTSC).
    localparam logic [8:0] LAST_VISIBLE = 9'(VBLANK_LINE - 2);

    logic [8:0] dot_q, dot_d;
    logic [8:0] scanline_q, scanline_d;
    logic       frame_odd_q, frame_odd_d;
    logic       vblank_q, vblank_d;

    logic render_line;
    logic active;
    logic skip_dot;
    logic line_end;
    logic vbl_set_evt;
    logic vbl_clr_evt;

    // ---------------- raster counters ----------------
    // On odd frames with rendering on, the pre-render line ends one dot early:
    // dot 339 goes straight to 0/0 and the frame wrap happens there instead.
    assign skip_dot = (scanline_q == PRE_LINE) && (dot_q == SKIP_DOT)
                      && renderingEnabled && frame_odd_q;
    assign line_end = (dot_q == LAST_DOT) || skip_dot;

    always_comb begin
        dot_d       = dot_q;
        scanline_d  = scanline_q;
        frame_odd_d = frame_odd_q;
        if (clock_EN) begin
            if (line_end) begin
                dot_d = 9'd0;
                if (scanline_q == PRE_LINE) begin
                    scanline_d  = 9'd0;
                    frame_odd_d = ~frame_odd_q;
                end else begin
                    scanline_d = scanline_q + 9'd1;
                end
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end
    end

    // ---------------- vblank flag ----------------
    assign vbl_set_evt = clock_EN && (scanline_q == VBL_LINE) && (dot_q == 9'd1);
    assign vbl_clr_evt = clock_EN && (scanline_q == PRE_LINE) && (dot_q == 9'd1);

    always_comb begin
        vblank_d = vblank_q;
        if (vbl_set_evt) begin
            vblank_d = 1'b1;
        end
        if (vbl_clr_evt) begin
            vblank_d = 1'b0;
        end
        // A status read always wins, including over a coincident set, which
        // suppresses the flag (and NMI) for the whole frame.
        if (vblankClear) begin
            vblank_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dot_q       <= 9'd0;
            scanline_q  <= 9'd0;
            frame_odd_q <= 1'b0;
            vblank_q    <= 1'b0;
        end else begin
            dot_q       <= dot_d;
            scanline_q  <= scanline_d;
            frame_odd_q <= frame_odd_d;
            vblank_q    <= vblank_d;
        end
    end

    // ---------------- per-dot decode ----------------
    assign render_line = (scanline_q <= LAST_VISIBLE) || (scanline_q == PRE_LINE);
    assign active      = render_line && renderingEnabled;

    assign backgroundFetch_EN = active && (((dot_q >= 9'd1)   && (dot_q <= 9'd256)) ||
                                           ((dot_q >= 9'd321) && (dot_q <= 9'd336)));
    assign spriteFetch_EN     = active && (dot_q >= 9'd257) && (dot_q <= 9'd320);
    assign dummyFetch_EN      = active && (dot_q >= 9'd337) && (dot_q <= 9'd340);
    assign idle               = ~(backgroundFetch_EN | spriteFetch_EN | dummyFetch_EN);

    // Coarse X steps at the last dot of each 8-dot tile fetch.
    assign coarseXIncrement = active && (dot_q[2:0] == 3'd0) &&
                              (((dot_q >= 9'd8)   && (dot_q <= 9'd256)) ||
                               ((dot_q >= 9'd328) && (dot_q <= 9'd336)));
    assign fineYIncrement   = active && (dot_q == 9'd256);
    assign copyHorizontal   = active && (dot_q == 9'd257);
    assign copyVertical     = active && (scanline_q == PRE_LINE) &&
                              (dot_q >= 9'd280) && (dot_q <= 9'd304);

    assign dot        = dot_q;
    assign scanline   = scanline_q;
    assign frameOdd   = frame_odd_q;
    assign vblankFlag = vblank_q;
    assign nmi_OUT    = vblank_q && nmiEnable;

endmodule

// File: tb/tb_ppu_fetch_scheduler.sv
// Testbench for ppu_fetch_scheduler. A short frame (20 lines, vblank on line
// 12) keeps multi-frame runs small; dot timing is full width (341 dots).
// The driver pushes the expected output vector for every checked cycle into
// a queue; the monitor pops and compares on the falling edge.
module tb_ppu_fetch_scheduler;

    localparam int NDOT  = 341;
    localparam int NLINE = 20;
    localparam int VBL   = 12;
    localparam int FS    = NDOT * NLINE;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clock_EN = 1'b0;
    logic       renderingEnabled = 1'b0;
    logic       nmiEnable = 1'b0;
    logic       vblankClear = 1'b0;
    logic [8:0] dot, scanline;
    logic       frameOdd, backgroundFetch_EN, spriteFetch_EN, dummyFetch_EN, idle;
    logic       coarseXIncrement, fineYIncrement, copyHorizontal, copyVertical;
    logic       vblankFlag, nmi_OUT;

    int vectors = 0;
    int miscompares = 0;

    // reference model: linear position within the frame
    int m_pos = 0;
    bit m_odd = 0;
    bit m_vbl = 0;

    logic [28:0] exp_q[$];

    ppu_fetch_scheduler #(
        .DOTS_PER_LINE(NDOT), .LINES_PER_FRAME(NLINE), .VBLANK_LINE(VBL)
    ) dut (
        .clock(clock), .reset(reset), .clock_EN(clock_EN),
        .renderingEnabled(renderingEnabled), .nmiEnable(nmiEnable),
        .vblankClear(vblankClear), .dot(dot), .scanline(scanline),
        .frameOdd(frameOdd), .backgroundFetch_EN(backgroundFetch_EN),
        .spriteFetch_EN(spriteFetch_EN), .dummyFetch_EN(dummyFetch_EN),
        .idle(idle), .coarseXIncrement(coarseXIncrement),
        .fineYIncrement(fineYIncrement), .copyHorizontal(copyHorizontal),
        .copyVertical(copyVertical), .vblankFlag(vblankFlag), .nmi_OUT(nmi_OUT)
    );

    always #5 clock = ~clock;

    function automatic logic [28:0] exp_vec(input int pos, input bit odd,
                                            input bit vbl, input bit rend,
                                            input bit nmi);
        int d, s;
        bit act, bg, sp, dm, cx, fy, ch, cv;
        d   = pos % NDOT;
        s   = pos / NDOT;
        act = rend && ((s <= VBL - 2) || (s == NLINE - 1));
        bg  = act && ((d >= 1 && d <= 256) || (d >= 321 && d <= 336));
        sp  = act && (d >= 257 && d <= 320);
        dm  = act && (d >= 337);
        cx  = act && (d % 8 == 0) && ((d >= 8 && d <= 256) || (d >= 328 && d <= 336));
        fy  = act && (d == 256);
        ch  = act && (d == 257);
        cv  = act && (s == NLINE - 1) && (d >= 280 && d <= 304);
        return {9'(d), 9'(s), odd, bg, sp, dm, !(bg || sp || dm),
                cx, fy, ch, cv, vbl, vbl && nmi};
    endfunction

    task automatic model_step(input bit en, input bit rend, input bit clr, input bit rst);
        if (rst) begin
            m_pos = 0;
            m_odd = 0;
            m_vbl = 0;
        end else begin
            if (en) begin
                if (m_pos == VBL * NDOT + 1) m_vbl = 1;
                if (m_pos == (NLINE - 1) * NDOT + 1) m_vbl = 0;
                if (m_pos == FS - 1 || (m_pos == FS - 2 && rend && m_odd)) begin
                    m_pos = 0;
                    m_odd = !m_odd;
                end else begin
                    m_pos++;
                end
            end
            if (clr) m_vbl = 0;
        end
    endtask

    // Called at posedge+1: apply inputs, queue the expectation, advance a cycle.
    task automatic tick(input bit en, input bit rend, input bit nmi,
                        input bit clr, input bit rst, input bit chk);
        clock_EN         = en;
        renderingEnabled = rend;
        nmiEnable        = nmi;
        vblankClear      = clr;
        reset            = rst;
        if (chk) exp_q.push_back(exp_vec(m_pos, m_odd, m_vbl, rend, nmi));
        @(posedge clock);
        model_step(en, rend, clr, rst);
        #1;
    endtask

    task automatic check(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end else begin
            $display("check %s: %0d", name, act);
        end
    endtask

    // Runs one frame from 0/0 with clock_EN held high, then checks its length,
    // the number of dots the vblank flag was seen high, and line-261 strobes.
    task automatic run_frame(input string tag, input bit rend, input bit clear_at_set,
                             input int exp_len, input int exp_vbl);
        int len = 0, vcnt = 0, cv = 0, cx = 0, fy = 0, ch = 0, fy_dot = -1, ch_dot = -1;
        bit done = 0, clr;
        while (!done && len < FS + 100) begin
            clr = clear_at_set && (m_pos == VBL * NDOT + 1);
            tick(1'b1, rend, 1'b1, clr, 1'b0, 1'b1);
            len++;
            if (dot == 9'd0 && scanline == 9'd0) begin
                done = 1;
            end else begin
                if (vblankFlag) vcnt++;
                if (int'(scanline) == NLINE - 1) begin
                    if (copyVertical) cv++;
                    if (coarseXIncrement) cx++;
                    if (fineYIncrement) begin fy++; fy_dot = int'(dot); end
                    if (copyHorizontal) begin ch++; ch_dot = int'(dot); end
                end
            end
        end
        check({tag, "_len"}, done ? len : -1, exp_len);
        check({tag, "_vblank_dots"}, vcnt, exp_vbl);
        if (rend) begin
            check({tag, "_copyV_count"}, cv, 25);
            check({tag, "_coarseX_count"}, cx, 34);
            check({tag, "_fineY_count"}, fy, 1);
            check({tag, "_fineY_dot"}, fy_dot, 256);
            check({tag, "_copyH_count"}, ch, 1);
            check({tag, "_copyH_dot"}, ch_dot, 257);
        end else begin
            check({tag, "_strobes_off"}, cv + cx + fy + ch, 0);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        logic [28:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {dot, scanline, frameOdd, backgroundFetch_EN, spriteFetch_EN,
                 dummyFetch_EN, idle, coarseXIncrement, fineYIncrement,
                 copyHorizontal, copyVertical, vblankFlag, nmi_OUT};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got %h, expected %h (dot/line exp %0d/%0d)",
                         $time, a, e, e[28:20], e[19:11]);
            end
            vectors++;
            if ($countones({backgroundFetch_EN, spriteFetch_EN, dummyFetch_EN, idle}) != 1) begin
                miscompares++;
                $display("FAIL onehot @%0t: got %b, expected exactly one set", $time,
                         {backgroundFetch_EN, spriteFetch_EN, dummyFetch_EN, idle});
            end
        end
    end

    initial begin
        bit r = 1;
        bit reached = 0;
        @(posedge clock);
        #1;
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);   // reset state, held in reset
        check("reset_state", int'({dot, scanline, frameOdd, idle, vblankFlag, nmi_OUT}),
              int'({9'd0, 9'd0, 1'b0, 1'b1, 1'b0, 1'b0}));

        // frame 0 even, rendering on: full length, vblank set at VBL/1
        run_frame("frame0_on", 1'b1, 1'b0, FS, NDOT * (NLINE - 1 - VBL));
        // frame 1 odd, rendering on: one dot short; status read hits the set dot
        run_frame("frame1_on_odd", 1'b1, 1'b1, FS - 1, 0);
        // rendering off: no skip on either parity
        run_frame("frame2_off", 1'b0, 1'b0, FS, NDOT * (NLINE - 1 - VBL));
        run_frame("frame3_off_odd", 1'b0, 1'b0, FS, NDOT * (NLINE - 1 - VBL));

        // randomized traffic
        for (int i = 0; i < 9000; i++) begin
            if ($urandom_range(9, 0) == 0) r = !r;
            tick($urandom_range(3, 0) != 0, r, 1'($urandom_range(1, 0)),
                 $urandom_range(99, 0) == 0, 1'b0, 1'b1);
        end

        // mid-frame reset at scanline 10, dot 200 with clock_EN low
        for (int i = 0; i < FS + 10 && !reached; i++) begin
            if (m_pos == 10 * NDOT + 200) reached = 1;
            else tick(1'b1, 1'b1, 1'($urandom_range(1, 0)), 1'b0, 1'b0, 1'b1);
        end
        check("reach_10_200", int'(reached), 1);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("midframe_reset", int'({dot, scanline, frameOdd, idle}),
              int'({9'd0, 9'd0, 1'b0, 1'b1}));
        tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
